instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Packs per-instruction field bundles into 32-bit block instruction words and writes them
//  sequentially into a block's program memory. Sits between the config/host loader and the
//  block instruction RAM; produces exactly the word layout the block's decoder consumes.
// PARAMETERS
//  ADDR_WIDTH  8  program memory address width; also width of the base and count inputs.
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   reset, synchronous, active-low
//  start        in   1   begin a load burst (honoured in IDLE only)
//  base_addr    in   AW  first write address, latched on start
//  count        in   AW  number of instructions in burst, latched on start
//  in_valid     in   1   field bundle valid
//  in_ready     out  1   encoder accepts bundle this cycle
//  operation    in   5   opcode
//  res_format   in   1   1 = resource format (res_addr), 0 = three-operand format
//  src_a,src_b,src_c in 4 each; src_a_reg,src_b_reg,src_c_reg in 1 each
//  dest         in   4   destination register
//  instr_shift  in   5   post-op shift
//  saturate     in   1   saturate result
//  no_shift     in   1   bypass shift
//  res_addr     in   8   resource address (format 1 only)
//  mem_we       out  1   program memory write strobe
//  mem_addr     out  AW  write address
//  mem_wdata    out  32  encoded instruction word
//  busy         out  1   burst in progress
//  done         out  1   one-cycle pulse, burst complete
//  error        out  1   sticky: unrepresentable field seen (see CONFIGURATION)
// BEHAVIOUR
//  Encoding, common: [4:0]=operation, [5]=res_format, [10:6]={src_a_reg,src_a},
//   [15:11]={src_b_reg,src_b}, [31]=no_shift.
//  Format 0: [20:16]={src_c_reg,src_c}, [24:21]=dest, [29:25]=instr_shift, [30]=~saturate.
//  Format 1: [19:16]=dest, [27:20]=res_addr, [30:28]=0; src_c/shift/saturate dropped.
//  Reset (reset_n=0 at clk edge): state IDLE; in_ready, mem_we, busy, done, error = 0;
//   mem_addr, mem_wdata = 0; internal address/remaining counters = 0.
//  FSM IDLE -> LOAD -> IDLE.
//   IDLE: in_ready=0, busy=0. start: latch base_addr/count, clear error. count==0 -> done
//    pulse next cycle, stay IDLE; else enter LOAD next cycle.
//   LOAD: busy=1; in_ready=1 while remaining>0. Accept = in_valid & in_ready.
//    Cycle after accept: mem_we=1, mem_addr=current address, mem_wdata=encoded word
//    (1-cycle latency, registered outputs). Address increments mod 2^ADDR_WIDTH (wraps,
//    no error). remaining decrements per accept.
//   Last accept: in_ready=0 from next cycle; done pulses in same cycle as final mem_we;
//    state returns to IDLE that cycle.
//  mem_we is never asserted outside the cycle following an accept; back-to-back accepts
//   give back-to-back writes at consecutive addresses.
//  start while busy: ignored. in_valid in IDLE: ignored, no write.
//  Reset mid-burst: aborts immediately, no done; memory already written is not undone.
// CONFIGURATION
//  INSTR_ENC_CHECK_EN defined: on accept of a format-1 bundle with src_c!=0, src_c_reg=1,
//   instr_shift!=0 or saturate=0, error sets (visible with that word's mem_we) and stays set
//   until next honoured start or reset; word is still written with fields dropped.
//  Not defined: error tied 0, fields dropped silently.
// TESTING
//  1. start base=0x10 count=1; bundle op=3,a=2/r0,b=5/r1,c=1/r0,dest=7,shift=4,sat=1,
//     no_shift=0,fmt=0 -> mem_we@0x10, wdata=0x08E1A883, done same cycle.
//  2. start count=1; fmt=1 op=1,a=3,dest=2,res_addr=0x5A,no_shift=1,rest 0
//     -> wdata=0x85A200E1.
//  3. start base=0xFE count=4, in_valid held high -> writes 0xFE,0xFF,0x00,0x01 on 4
//     consecutive cycles; in_ready low after 4th accept; single done pulse.
//  4. count=0 -> done pulse one cycle after start, no mem_we, busy stays 0.
//  5. reset_n low after 2 of 5 writes -> all outputs 0 next cycle, no done; new start
//     works normally.
//  6. CHECK_EN: fmt=1 with shift=3 -> error=1 with the write, held until next start;
//     without macro error stays 0.

Source files
------------

// File: rtl/instr_enc_if.sv
// Host/loader and program-memory signal bundle for instr_encoder.
interface instr_enc_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] count;
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            operation;
    logic                  res_format;
    logic [3:0]            src_a;
    logic [3:0]            src_b;
    logic [3:0]            src_c;
    logic                  src_a_reg;
    logic                  src_b_reg;
    logic                  src_c_reg;
    logic [3:0]            dest;
    logic [4:0]            instr_shift;
    logic                  saturate;
    logic                  no_shift;
    logic [7:0]            res_addr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, base_addr, count, in_valid, operation, res_format,
               src_a, src_b, src_c, src_a_reg, src_b_reg, src_c_reg,
               dest, instr_shift, saturate, no_shift, res_addr,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
    );

    modport slave (
        input  start, base_addr, count, in_valid, operation, res_format,
               src_a, src_b, src_c, src_a_reg, src_b_reg, src_c_reg,
               dest, instr_shift, saturate, no_shift, res_addr,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs field bundles into 32-bit block instruction words and writes them sequentially.
// Optional INSTR_ENC_CHECK_EN flags format-1 bundles carrying fields that would be dropped.
module instr_encoder #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic         clk,
    input logic         reset_n,
    instr_enc_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [31:0]           enc_word;
    logic                  in_ready;
    logic                  accept;
    logic                  field_err;

    always_comb begin
        enc_word        = '0;
        enc_word[4:0]   = bus.operation;
        enc_word[5]     = bus.res_format;
        enc_word[10:6]  = {bus.src_a_reg, bus.src_a};
        enc_word[15:11] = {bus.src_b_reg, bus.src_b};
        enc_word[31]    = bus.no_shift;
        if (bus.res_format) begin
            enc_word[19:16] = bus.dest;
            enc_word[27:20] = bus.res_addr;
            enc_word[30:28] = 3'b000;
        end else begin
            enc_word[20:16] = {bus.src_c_reg, bus.src_c};
            enc_word[24:21] = bus.dest;
            enc_word[29:25] = bus.instr_shift;
            enc_word[30]    = ~bus.saturate;
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    // Fields that format 1 has no room for; the word is still written without them.
    assign field_err = bus.res_format & ((bus.src_c != 4'd0) | bus.src_c_reg |
                                         (bus.instr_shift != 5'd0) | ~bus.saturate);
`else
    assign field_err = 1'b0;
`endif

    assign in_ready = (state_q == StLoad) && (remaining_q != '0);
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        mem_we_d    = 1'b0;
        done_d      = 1'b0;
        error_d     = error_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d      = bus.base_addr;
                    remaining_d = bus.count;
                    error_d     = 1'b0;
                    if (bus.count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    wdata_d     = enc_word;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - ADDR_WIDTH'(1);
                    if (field_err) begin
                        error_d = 1'b1;
                    end
                    // Final word: done lines up with its write strobe.
                    if (remaining_q == ADDR_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q == StLoad);
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encoding, bursts, wrap, reset abort, error flag.
module tb_instr_encoder;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

`ifdef INSTR_ENC_CHECK_EN
    localparam logic ExpErr = 1'b1;
`else
    localparam logic ExpErr = 1'b0;
`endif

    instr_enc_if #(.ADDR_WIDTH(8)) bus ();

    instr_encoder #(.ADDR_WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_bundle();
        bus.operation   = '0;
        bus.res_format  = 1'b0;
        bus.src_a       = '0;
        bus.src_b       = '0;
        bus.src_c       = '0;
        bus.src_a_reg   = 1'b0;
        bus.src_b_reg   = 1'b0;
        bus.src_c_reg   = 1'b0;
        bus.dest        = '0;
        bus.instr_shift = '0;
        bus.saturate    = 1'b0;
        bus.no_shift    = 1'b0;
        bus.res_addr    = '0;
    endtask

    // op=3 a=2/r0 b=5/r1 c=1/r0 dest=7 shift=4 sat=1 fmt0 -> 0x08E1A883
    task automatic bundle_t1();
        clear_bundle();
        bus.operation   = 5'd3;
        bus.src_a       = 4'd2;
        bus.src_b       = 4'd5;
        bus.src_b_reg   = 1'b1;
        bus.src_c       = 4'd1;
        bus.dest        = 4'd7;
        bus.instr_shift = 5'd4;
        bus.saturate    = 1'b1;
    endtask

    task automatic start_burst(input logic [7:0] base, input logic [7:0] cnt);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.count     = cnt;
        tick();
        bus.start     = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.base_addr = '0;
        bus.count  = '0;
        bus.in_valid = 1'b0;
        clear_bundle();
        tick();
        tick();
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // Test 1: three-operand format
        start_burst(8'h10, 8'd1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        bundle_t1();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("t1_mem_we", 32'(bus.mem_we), 32'd1);
        check("t1_mem_addr", 32'(bus.mem_addr), 32'h10);
        check("t1_wdata", bus.mem_wdata, 32'h08E1A883);
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        check("t1_we_after", 32'(bus.mem_we), 32'd0);
        check("t1_done_after", 32'(bus.done), 32'd0);

        // Test 2: resource format
        start_burst(8'h20, 8'd1);
        clear_bundle();
        bus.res_format = 1'b1;
        bus.operation  = 5'd1;
        bus.src_a      = 4'd3;
        bus.dest       = 4'd2;
        bus.res_addr   = 8'h5A;
        bus.no_shift   = 1'b1;
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("t2_mem_we", 32'(bus.mem_we), 32'd1);
        check("t2_mem_addr", 32'(bus.mem_addr), 32'h20);
        check("t2_wdata", bus.mem_wdata, 32'h85A200E1);
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_error", 32'(bus.error), 32'(ExpErr));
        tick();

        // Test 3: burst of 4 wrapping through 0xFF, with a stray start mid-burst
        bundle_t1();
        start_burst(8'hFE, 8'd4);
        bus.in_valid = 1'b1;
        tick();
        check("t3_we0", 32'(bus.mem_we), 32'd1);
        check("t3_addr0", 32'(bus.mem_addr), 32'hFE);
        check("t3_done0", 32'(bus.done), 32'd0);
        check("t3_busy0", 32'(bus.busy), 32'd1);
        check("t3_error_cleared", 32'(bus.error), 32'd0);
        bus.start     = 1'b1;
        bus.base_addr = 8'h99;
        bus.count     = 8'd0;
        tick();
        bus.start = 1'b0;
        check("t3_we1", 32'(bus.mem_we), 32'd1);
        check("t3_addr1", 32'(bus.mem_addr), 32'hFF);
        check("t3_done1", 32'(bus.done), 32'd0);
        tick();
        check("t3_we2", 32'(bus.mem_we), 32'd1);
        check("t3_addr2", 32'(bus.mem_addr), 32'h00);
        tick();
        check("t3_we3", 32'(bus.mem_we), 32'd1);
        check("t3_addr3", 32'(bus.mem_addr), 32'h01);
        check("t3_done3", 32'(bus.done), 32'd1);
        check("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("t3_we_after", 32'(bus.mem_we), 32'd0);
        check("t3_done_after", 32'(bus.done), 32'd0);

        // Test 4: zero-length burst; in_valid in idle must not write
        bus.in_valid = 1'b1;
        start_burst(8'h30, 8'd0);
        check("t4_done", 32'(bus.done), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        check("t4_we", 32'(bus.mem_we), 32'd0);
        tick();
        check("t4_done_after", 32'(bus.done), 32'd0);
        check("t4_we_after", 32'(bus.mem_we), 32'd0);
        bus.in_valid = 1'b0;

        // Test 5: reset after 2 of 5 writes
        bus.in_valid = 1'b1;
        start_burst(8'h40, 8'd5);
        tick();
        check("t5_addr0", 32'(bus.mem_addr), 32'h40);
        tick();
        check("t5_addr1", 32'(bus.mem_addr), 32'h41);
        reset_n = 1'b0;
        tick();
        check("t5_rst_we", 32'(bus.mem_we), 32'd0);
        check("t5_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("t5_rst_wdata", bus.mem_wdata, 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("t5_rst_done", 32'(bus.done), 32'd0);
        reset_n = 1'b1;
        tick();
        check("t5_idle_we", 32'(bus.mem_we), 32'd0);
        check("t5_idle_done", 32'(bus.done), 32'd0);
        start_burst(8'h50, 8'd1);
        tick();
        bus.in_valid = 1'b0;
        check("t5_restart_we", 32'(bus.mem_we), 32'd1);
        check("t5_restart_addr", 32'(bus.mem_addr), 32'h50);
        check("t5_restart_wdata", bus.mem_wdata, 32'h08E1A883);
        check("t5_restart_done", 32'(bus.done), 32'd1);
        tick();

        // Test 6: format-1 bundle with a nonzero shift
        start_burst(8'h60, 8'd1);
        clear_bundle();
        bus.res_format  = 1'b1;
        bus.operation   = 5'd2;
        bus.dest        = 4'd1;
        bus.res_addr    = 8'h11;
        bus.instr_shift = 5'd3;
        bus.saturate    = 1'b1;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("t6_we", 32'(bus.mem_we), 32'd1);
        check("t6_wdata", bus.mem_wdata, 32'h01110022);
        check("t6_error", 32'(bus.error), 32'(ExpErr));
        tick();
        tick();
        check("t6_error_held", 32'(bus.error), 32'(ExpErr));
        start_burst(8'h70, 8'd0);
        check("t6_error_cleared", 32'(bus.error), 32'd0);
        check("t6_done", 32'(bus.done), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
